// File: rtl/mem_bus_arbiter_pkg.sv
// Purpose: shared definitions for the data-side bus arbiter: address map,
//          access size / state / master enums, bus payload struct and
//          address decode helpers.
// Ports:   none (package).
package mem_bus_arbiter_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = 4;
    localparam int unsigned SelW  = 3;

    localparam logic [DataW-1:0] DmStartAddr  = 32'h0000_0000;
    localparam logic [DataW-1:0] DmEndAddr    = 32'h0000_2FFF;
    localparam logic [DataW-1:0] Tc0StartAddr = 32'h0000_7F00;
    localparam logic [DataW-1:0] Tc0EndAddr   = 32'h0000_7F0B;
    localparam logic [DataW-1:0] Tc1StartAddr = 32'h0000_7F10;
    localparam logic [DataW-1:0] Tc1EndAddr   = 32'h0000_7F1B;

    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_t;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {M_CPU = 1'b0, M_DMA = 1'b1} master_t;

    // Payload driven onto the shared bus during ACCESS; sel is one-hot {TC1, TC0, DM}.
    typedef struct packed {
        logic [SelW-1:0]  sel;
        logic             we;
        logic [BeW-1:0]   be;
        logic [DataW-1:0] addr;
        logic [DataW-1:0] wdata;
    } bus_req_t;

    // Unsigned offset compare: one subtract covers both bounds, even when lo is 0.
    function automatic logic in_range(input logic [DataW-1:0] a,
                                      input logic [DataW-1:0] lo,
                                      input logic [DataW-1:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

    function automatic logic [SelW-1:0] decode_sel(input logic [DataW-1:0] a);
        return {in_range(a, Tc1StartAddr, Tc1EndAddr),
                in_range(a, Tc0StartAddr, Tc0EndAddr),
                in_range(a, DmStartAddr,  DmEndAddr)};
    endfunction

    // Size code 3 behaves as a word access.
    function automatic size_t norm_size(input logic [1:0] s);
        return (s == 2'd3) ? WORD : size_t'(s);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_lane_gen.sv
// Purpose: combinational byte-enable and write-data lane replication.
// Ports:   i_size      access size
//          i_addr_lo   byte offset within the word
//          i_wdata     right-aligned store data
//          o_be_c      byte enables
//          o_wdata_c   write data replicated across the active lanes
module bus_lane_gen
    import mem_bus_arbiter_pkg::*;
(
    input  size_t              i_size,
    input  logic [1:0]         i_addr_lo,
    input  logic [DataW-1:0]   i_wdata,
    output logic [BeW-1:0]     o_be_c,
    output logic [DataW-1:0]   o_wdata_c
);

    always_comb begin
        o_be_c    = 4'b1111;
        o_wdata_c = i_wdata;
        case (i_size)
            BYTE: begin
                o_be_c    = 4'b0001 << i_addr_lo;
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            HALF: begin
                o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: round-robin arbiter sharing the DM/TC0/TC1 data bus between the
//          CPU MEM stage and a word-only DMA/debug port, with store legality
//          check, DM timeout and registered one-cycle completion.
// Ports:   i_cpu_*   CPU request (held until o_cpu_ready), o_cpu_* response
//          o_cpu_stall  pipeline freeze while a CPU access is pending
//          i_dma_*   DMA request, o_dma_* response
//          o_bus_*   shared bus (registered, non-zero only in ACCESS)
//          i_dm_rdata/i_tc0_rdata/i_tc1_rdata/i_dm_ack  slave returns
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          DMA_ENABLE     = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [1:0]        i_cpu_size,
    input  logic [DataW-1:0]  i_cpu_addr,
    input  logic [DataW-1:0]  i_cpu_wdata,
    output logic [DataW-1:0]  o_cpu_rdata,
    output logic              o_cpu_ready,
    output logic              o_cpu_err,
    output logic              o_cpu_stall,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [DataW-1:0]  i_dma_addr,
    input  logic [DataW-1:0]  i_dma_wdata,
    output logic [DataW-1:0]  o_dma_rdata,
    output logic              o_dma_ready,
    output logic              o_dma_err,
    output logic [SelW-1:0]   o_bus_sel,
    output logic              o_bus_we,
    output logic [BeW-1:0]    o_bus_be,
    output logic [DataW-1:0]  o_bus_addr,
    output logic [DataW-1:0]  o_bus_wdata,
    input  logic [DataW-1:0]  i_dm_rdata,
    input  logic [DataW-1:0]  i_tc0_rdata,
    input  logic [DataW-1:0]  i_tc1_rdata,
    input  logic              i_dm_ack
);

    localparam int unsigned   TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state, w_state_nxt;
    master_t          r_last_grant, w_last_grant_nxt;
    master_t          r_grant, w_grant_nxt;
    bus_req_t         r_bus, w_bus_nxt;
    logic [TmoW-1:0]  r_tmo, w_tmo_nxt;
    logic [DataW-1:0] r_cpu_rdata, w_cpu_rdata_nxt, r_dma_rdata, w_dma_rdata_nxt;
    logic             r_cpu_ready, w_cpu_ready_nxt, r_cpu_err, w_cpu_err_nxt;
    logic             r_dma_ready, w_dma_ready_nxt, r_dma_err, w_dma_err_nxt;

    logic             w_dma_req, w_any_req, w_we, w_misalign, w_legal;
    master_t          w_win;
    size_t            w_size;
    logic [DataW-1:0] w_addr, w_wdata, w_lane_wdata;
    logic [SelW-1:0]  w_sel;
    logic [BeW-1:0]   w_be;
    logic             w_fin, w_fin_err;
    logic [DataW-1:0] w_fin_rdata;
    master_t          w_fin_master;

    assign w_dma_req = DMA_ENABLE && i_dma_req;
    assign w_any_req = i_cpu_req || w_dma_req;

    // Round-robin on ties: the master that did not win last time goes first.
    always_comb begin
        w_win = M_CPU;
        if (i_cpu_req && w_dma_req)
            w_win = (r_last_grant == M_DMA) ? M_CPU : M_DMA;
        else if (w_dma_req)
            w_win = M_DMA;
    end

    assign w_we    = (w_win == M_CPU) ? i_cpu_we    : i_dma_we;
    assign w_size  = (w_win == M_CPU) ? norm_size(i_cpu_size) : WORD;
    assign w_addr  = (w_win == M_CPU) ? i_cpu_addr  : i_dma_addr;
    assign w_wdata = (w_win == M_CPU) ? i_cpu_wdata : i_dma_wdata;
    assign w_sel   = decode_sel(w_addr);

    assign w_misalign = (w_size == WORD) ? (|w_addr[1:0]) :
                        (w_size == HALF) ? w_addr[0] : 1'b0;

    // CPU loads are never rejected here; an unmapped load completes with zero data.
    assign w_legal = (w_win == M_CPU)
                   ? !(w_we && ((w_sel == '0) || w_misalign ||
                                ((w_sel[1] || w_sel[2]) && (w_size != WORD))))
                   : (!(|w_addr[1:0]) && w_sel[0]);

    bus_lane_gen u_lane_gen (
        .i_size    (w_size),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .o_be_c    (w_be),
        .o_wdata_c (w_lane_wdata)
    );

    // Next-state, bus payload and completion logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_bus_nxt        = '0;
        w_tmo_nxt        = '0;
        w_fin            = 1'b0;
        w_fin_err        = 1'b0;
        w_fin_rdata      = '0;
        w_fin_master     = r_grant;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt      = w_win;
                    w_last_grant_nxt = w_win;
                    w_fin_master     = w_win;
                    if (w_legal) begin
                        w_state_nxt = ACCESS;
                        if (w_sel != '0) begin
                            w_bus_nxt.sel   = w_sel;
                            w_bus_nxt.we    = w_we;
                            w_bus_nxt.be    = w_be;
                            w_bus_nxt.addr  = {w_addr[31:2], 2'b00};
                            w_bus_nxt.wdata = w_lane_wdata;
                        end
                    end else begin
                        w_state_nxt = DONE;
                        w_fin       = 1'b1;
                        w_fin_err   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                w_bus_nxt = r_bus;
                w_tmo_nxt = r_tmo + TmoW'(1);
                if (r_bus.sel[1]) begin
                    w_fin       = 1'b1;
                    w_fin_rdata = i_tc0_rdata;
                end else if (r_bus.sel[2]) begin
                    w_fin       = 1'b1;
                    w_fin_rdata = i_tc1_rdata;
                end else if (r_bus.sel[0]) begin
                    if (i_dm_ack) begin
                        w_fin       = 1'b1;
                        w_fin_rdata = i_dm_rdata;
                    end else if (r_tmo == TmoLast) begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end
                end else begin
                    w_fin = 1'b1;
                end
                if (w_fin) begin
                    w_state_nxt = DONE;
                    w_bus_nxt   = '0;
                    w_tmo_nxt   = '0;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_cpu_ready_nxt = w_fin && (w_fin_master == M_CPU);
        w_cpu_err_nxt   = w_cpu_ready_nxt && w_fin_err;
        w_cpu_rdata_nxt = w_cpu_ready_nxt ? w_fin_rdata : '0;
        w_dma_ready_nxt = w_fin && (w_fin_master == M_DMA);
        w_dma_err_nxt   = w_dma_ready_nxt && w_fin_err;
        w_dma_rdata_nxt = w_dma_ready_nxt ? w_fin_rdata : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= M_DMA;
            r_grant      <= M_CPU;
            r_bus        <= '0;
            r_tmo        <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ready  <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dma_rdata  <= '0;
            r_dma_ready  <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_bus        <= w_bus_nxt;
            r_tmo        <= w_tmo_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_cpu_ready  <= w_cpu_ready_nxt;
            r_cpu_err    <= w_cpu_err_nxt;
            r_dma_rdata  <= w_dma_rdata_nxt;
            r_dma_ready  <= w_dma_ready_nxt;
            r_dma_err    <= w_dma_err_nxt;
        end
    end

    // Stall must rise in the request cycle itself, so it is the one combinational output.
    assign o_cpu_stall = rst_n && i_cpu_req && !r_cpu_ready;

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ready = r_cpu_ready;
    assign o_cpu_err   = r_cpu_err;
    assign o_dma_rdata = r_dma_rdata;
    assign o_dma_ready = r_dma_ready;
    assign o_dma_err   = r_dma_err;
    assign o_bus_sel   = r_bus.sel;
    assign o_bus_we    = r_bus.we;
    assign o_bus_be    = r_bus.be;
    assign o_bus_addr  = r_bus.addr;
    assign o_bus_wdata = r_bus.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter: table of single accesses
//          plus hand-written reset-abort and round-robin sequences.
module tb_mem_bus_arbiter;

    localparam logic [31:0] DmData  = 32'hDEAD_BEEF;
    localparam logic [31:0] Tc0Data = 32'h0C0C_0C0C;
    localparam logic [31:0] Tc1Data = 32'h1C1C_1C1C;

    logic        clk, rst_n;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_err, cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ready, dma_err;
    logic [2:0]  bus_sel;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;
    logic        dm_ack;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .DMA_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready), .o_cpu_err(cpu_err),
        .o_cpu_stall(cpu_stall),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
        .i_dma_wdata(dma_wdata),
        .o_dma_rdata(dma_rdata), .o_dma_ready(dma_ready), .o_dma_err(dma_err),
        .o_bus_sel(bus_sel), .o_bus_we(bus_we), .o_bus_be(bus_be),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
        .i_dm_rdata(dm_rdata), .i_tc0_rdata(tc0_rdata), .i_tc1_rdata(tc1_rdata),
        .i_dm_ack(dm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wait_n: ACCESS cycles without ack before dm_ack (-1 = never); lat: cycle of ready.
    typedef struct {
        bit          dma;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [2:0]  sel;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] baddr;
        int          lat;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit done = 0;
        @(negedge clk);
        cpu_req = !v.dma; cpu_we = v.we; cpu_size = v.size;
        cpu_addr = v.addr; cpu_wdata = v.wdata;
        dma_req = v.dma;  dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        dm_ack = 1'b0;
        #1;
        chk($sformatf("v%0d stall_c0", idx), 32'(cpu_stall), 32'(!v.dma));
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                chk($sformatf("v%0d bus_sel", idx),   32'(bus_sel), 32'(v.sel));
                chk($sformatf("v%0d bus_be", idx),    32'(bus_be),  32'(v.be));
                chk($sformatf("v%0d bus_we", idx),    32'(bus_we),  32'(v.we && (v.sel != 3'b000)));
                chk($sformatf("v%0d bus_addr", idx),  bus_addr,  v.baddr);
                chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
            end
            if (v.dma ? cpu_ready : dma_ready)
                chk($sformatf("v%0d wrong_master_ready", idx), 32'd1, 32'd0);
            if (v.dma ? dma_ready : cpu_ready) begin
                done = 1;
                chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
                chk($sformatf("v%0d err", idx),   32'(v.dma ? dma_err : cpu_err), 32'(v.err));
                chk($sformatf("v%0d rdata", idx), v.dma ? dma_rdata : cpu_rdata, v.rd);
                chk($sformatf("v%0d bus_idle_done", idx), 32'(bus_sel), 32'd0);
                cpu_req = 1'b0; dma_req = 1'b0; dm_ack = 1'b0;
            end else begin
                if (!v.dma) chk($sformatf("v%0d stall", idx), 32'(cpu_stall), 32'd1);
                dm_ack = (v.wait_n >= 0) && (cyc >= 1 + v.wait_n);
            end
        end
        if (!done) chk($sformatf("v%0d ready_timeout", idx), 32'd0, 32'd1);
        @(posedge clk); #1;
        chk($sformatf("v%0d rdata_clear", idx), v.dma ? dma_rdata : cpu_rdata, 32'd0);
    endtask

    initial begin
        // dma we size addr wdata wait | sel be bwd baddr lat err rd
        vecs[0]  = '{0, 0, 2'd2, 32'h0000_0010, 32'h0,          0, 3'b001, 4'b1111, 32'h0,          32'h0000_0010, 2,  0, DmData};
        vecs[1]  = '{0, 1, 2'd0, 32'h0000_0103, 32'h0000_00A5,  0, 3'b001, 4'b1000, 32'hA5A5_A5A5,  32'h0000_0100, 2,  0, DmData};
        vecs[2]  = '{0, 1, 2'd1, 32'h0000_0102, 32'h0000_1234,  2, 3'b001, 4'b1100, 32'h1234_1234,  32'h0000_0100, 4,  0, DmData};
        vecs[3]  = '{0, 1, 2'd1, 32'h0000_7F04, 32'h0000_5678,  0, 3'b000, 4'b0000, 32'h0,          32'h0,         1,  1, 32'h0};
        vecs[4]  = '{0, 1, 2'd2, 32'h0000_0002, 32'h0000_0001,  0, 3'b000, 4'b0000, 32'h0,          32'h0,         1,  1, 32'h0};
        vecs[5]  = '{0, 0, 2'd2, 32'h0000_8000, 32'h0,          0, 3'b000, 4'b0000, 32'h0,          32'h0,         2,  0, 32'h0};
        vecs[6]  = '{0, 0, 2'd2, 32'h0000_7F04, 32'h0,          0, 3'b010, 4'b1111, 32'h0,          32'h0000_7F04, 2,  0, Tc0Data};
        vecs[7]  = '{0, 1, 2'd2, 32'h0000_7F18, 32'hCAFE_F00D,  0, 3'b100, 4'b1111, 32'hCAFE_F00D,  32'h0000_7F18, 2,  0, Tc1Data};
        vecs[8]  = '{0, 0, 2'd0, 32'h0000_2FFF, 32'h0,          0, 3'b001, 4'b1000, 32'h0,          32'h0000_2FFC, 2,  0, DmData};
        vecs[9]  = '{0, 1, 2'd2, 32'h0000_3000, 32'h0000_0001,  0, 3'b000, 4'b0000, 32'h0,          32'h0,         1,  1, 32'h0};
        vecs[10] = '{0, 0, 2'd1, 32'h0000_7F0A, 32'h0,          0, 3'b010, 4'b1100, 32'h0,          32'h0000_7F08, 2,  0, Tc0Data};
        vecs[11] = '{1, 0, 2'd2, 32'h0000_0200, 32'h0,          1, 3'b001, 4'b1111, 32'h0,          32'h0000_0200, 3,  0, DmData};
        vecs[12] = '{1, 1, 2'd2, 32'h0000_0204, 32'h55AA_55AA,  0, 3'b001, 4'b1111, 32'h55AA_55AA,  32'h0000_0204, 2,  0, DmData};
        vecs[13] = '{1, 0, 2'd2, 32'h0000_7F00, 32'h0,          0, 3'b000, 4'b0000, 32'h0,          32'h0,         1,  1, 32'h0};
        vecs[14] = '{1, 0, 2'd2, 32'h0000_0202, 32'h0,          0, 3'b000, 4'b0000, 32'h0,          32'h0,         1,  1, 32'h0};
        vecs[15] = '{0, 0, 2'd2, 32'h0000_0040, 32'h0,         -1, 3'b001, 4'b1111, 32'h0,          32'h0000_0040, 17, 1, 32'h0};
        vecs[16] = '{0, 1, 2'd3, 32'h0000_0008, 32'h0102_0304,  0, 3'b001, 4'b1111, 32'h0102_0304,  32'h0000_0008, 2,  0, DmData};

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        dm_rdata = DmData; tc0_rdata = Tc0Data; tc1_rdata = Tc1Data; dm_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst bus_sel",   32'(bus_sel), 32'd0);
        chk("rst bus_be_we", 32'({bus_be, bus_we}), 32'd0);
        chk("rst bus_addr",  bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst ready",     32'({cpu_ready, cpu_err, dma_ready, dma_err}), 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        chk("rst dma_rdata", dma_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Reset during the third DM ACCESS cycle aborts the access.
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h20; dm_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort pre bus_sel", 32'(bus_sel), 32'b001);
        rst_n = 1'b0;
        #1;
        chk("abort bus_sel",    32'(bus_sel), 32'd0);
        chk("abort bus_be_we",  32'({bus_be, bus_we}), 32'd0);
        chk("abort bus_addr",   bus_addr, 32'd0);
        chk("abort cpu_out",    32'({cpu_ready, cpu_err, cpu_stall}), 32'd0);
        dma_req = 1; dma_we = 0; dma_addr = 32'h300; dm_ack = 1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("abort no_ready", 32'({cpu_ready, dma_ready}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Both requests held from the first post-reset cycle: strict alternation, CPU first.
        begin
            string order = "";
            int    first_cyc = -1;
            for (int cyc = 1; cyc <= 20 && order.len() < 4; cyc++) begin
                @(posedge clk); #1;
                if (cpu_ready && dma_ready) order = {order, "B"};
                else if (cpu_ready) begin
                    order = {order, "C"};
                    if (first_cyc < 0) first_cyc = cyc;
                    chk("rr cpu_rdata", cpu_rdata, DmData);
                end else if (dma_ready) begin
                    order = {order, "D"};
                    chk("rr dma_rdata", dma_rdata, DmData);
                end
            end
            total++;
            if (order != "CDCD") begin
                bad++;
                $display("FAIL rr order: got %s expected CDCD", order);
            end
            chk("rr first_latency", 32'(first_cyc), 32'd2);
        end
        cpu_req = 0; dma_req = 0; dm_ack = 0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
